stream_mux: RTL

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/stream_mux_rr_arbiter.sv | 36 +++
 rtl/stream_mux.sv | 87 ++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux shared helpers.
// Width and pointer arithmetic used by the mux and its arbiter.
package stream_mux_pkg;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: one-hot grant plus encoded index.
// Round-robin from a pointer, or fixed lowest-index priority.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   idx_o
);

  logic found;
  int   c;

  // Scan from the start channel and take the first requester.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (RR_MODE != 0) c = (int'(ptr_i) + off) % NUM_CH;
      else              c = off;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-to-1 valid/ready mux with one output register.
// Full throughput; arbitration is round-robin or fixed priority.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int RR_MODE    = 1,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;

  logic                  load_en;
  logic                  in_hs;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       idx;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (idx)
  );

  // Register may load when empty or being drained this cycle.
  always_comb begin
    load_en  = !valid_q | out_ready;
    in_ready = rst_n ? (grant & {NUM_CH{load_en}}) : '0;
    in_hs    = |in_ready;
    sel_data = in_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next output register and pointer state.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (in_hs) begin
      valid_d = 1'b1;
      data_d  = sel_data;
      ch_d    = idx;
      if (RR_MODE != 0)
        ptr_d = CH_W'(wrap_inc(int'(idx), NUM_CH));
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
